// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester valid/ready/data/last lanes plus transmitter start/busy, grant status and timeout error
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0] req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  logic grant_active;
  logic [1:0] grant_id;
  logic err_clr;
  logic err_timeout;
  modport master (
    output req_valid, req_data, req_last, tx_busy, err_clr,
    input req_ready, tx_data, tx_start, grant_active, grant_id, err_timeout
  );
  modport slave (
    input req_valid, req_data, req_last, tx_busy, err_clr,
    output req_ready, tx_data, tx_start, grant_active, grant_id, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte sources (clk, rst, bus slave modport)
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MAX_BURST = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, OWN, START, WAIT_ACK, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [1:0] gid, gid_n, last_grant, last_grant_n, sel, idx;
  logic [7:0] cnt, cnt_n, data, data_n;
  logic [15:0] timer, timer_n;
  logic last, last_n, err, err_n, any, done, rel, timeout;
  logic [3:0] valid4, last4;
  logic [31:0] data4;
  assign valid4 = 4'(bus.req_valid);
  assign last4 = 4'(bus.req_last);
  assign data4 = 32'(bus.req_data);
  assign timeout = ({16'd0, timer} + 32'd1) >= 32'(ACK_TIMEOUT - 1);
  assign rel = last || cnt == 8'(MAX_BURST);
  assign bus.req_ready = NUM_REQ'(state == OWN ? 4'b0001 << gid : 4'b0000);
  assign bus.tx_start = state == START && !bus.tx_busy;
  assign bus.tx_data = data;
  assign bus.grant_active = state != IDLE;
  assign bus.grant_id = gid;
  assign bus.err_timeout = err;
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = 2'((int'(last_grant) + k) % NUM_REQ);
      if (valid4[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    gid_n = gid;
    last_grant_n = last_grant;
    cnt_n = cnt;
    data_n = data;
    last_n = last;
    timer_n = timer;
    err_n = err & ~bus.err_clr;
    done = 1'b0;
    unique case (state)
      IDLE: if (any) begin
        state_n = OWN;
        gid_n = sel;
        cnt_n = '0;
      end
      OWN: if (valid4[gid]) begin
        state_n = START;
        data_n = data4[{gid, 3'b000} +: 8];
        last_n = last4[gid];
        cnt_n = cnt + 8'd1;
      end else if (cnt == 8'd0) state_n = IDLE;
      START: if (!bus.tx_busy) begin
        state_n = WAIT_ACK;
        timer_n = '0;
      end
      WAIT_ACK: if (bus.tx_busy) state_n = WAIT_DONE;
      else if (timeout) begin
        err_n = 1'b1;
        done = 1'b1;
      end else timer_n = timer + 16'd1;
      WAIT_DONE: done = !bus.tx_busy;
      default: state_n = IDLE;
    endcase
    if (done) begin
      state_n = rel ? IDLE : OWN;
      last_grant_n = rel ? gid : last_grant;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gid <= '0;
      last_grant <= 2'(NUM_REQ - 1);
      cnt <= '0;
      data <= '0;
      last <= 1'b0;
      timer <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      gid <= gid_n;
      last_grant <= last_grant_n;
      cnt <= cnt_n;
      data <= data_n;
      last <= last_n;
      timer <= timer_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and randomized messages against a queue-based model
module tb_uart_tx_arbiter;
  localparam int N = 3, MB = 4, AT = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .ACK_TIMEOUT(AT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, failures = 0;
  logic man_en = 1'b0, man_busy = 1'b0, stuck = 1'b0, rnd_busy = 1'b0;
  int busy_len = 3;
  int tx_cnt = 0;
  logic [9:0] log_q[$];
  logic [8:0] mq[N][$];

  typedef struct packed {
    logic [2:0] v, l;
    logic [23:0] d;
    logic b;
    logic [2:0] rdy;
    logic st, act;
    logic [1:0] gid;
    logic [7:0] txd;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  assign bus.tx_busy = man_en ? man_busy : (tx_cnt != 0);

  always @(posedge clk) begin
    if (bus.tx_start && !stuck && !man_en) tx_cnt <= rnd_busy ? int'($urandom_range(5, 1)) : busy_len;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    if (bus.tx_start) begin
      log_q.push_back({bus.grant_id, bus.tx_data});
      chk("start_while_busy", 64'(bus.tx_busy), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.err_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.tx_start && n < 20);
    bus.req_valid = '0;
    chk(name, 64'(bus.tx_start), 1);
  endtask

  task automatic run(input int budget);
    int n = 0;
    logic [N-1:0] hs;
    while ((mq[0].size() + mq[1].size() + mq[2].size() > 0 || bus.grant_active) && n < budget) begin
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = mq[i].size() > 0;
        bus.req_last[i] = mq[i].size() > 0 ? mq[i][0][8] : 1'b0;
        bus.req_data[8*i +: 8] = mq[i].size() > 0 ? mq[i][0][7:0] : 8'h00;
      end
      hs = bus.req_valid & bus.req_ready;
      step();
      n++;
      for (int i = 0; i < N; i++) if (hs[i]) void'(mq[i].pop_front());
    end
    bus.req_valid = '0;
    chk("run_budget", 64'(n < budget), 1);
  endtask

  // Expected transmit order: round robin from the last released owner,
  // each grant carrying bytes until a last flag or MB bytes.
  task automatic predict(output logic [9:0] exp[$]);
    logic [8:0] mm[N][$];
    logic [8:0] e;
    int lg = N - 1, id, cnt;
    for (int i = 0; i < N; i++) mm[i] = mq[i];
    exp.delete();
    while (1) begin
      id = -1;
      for (int k = 1; k <= N; k++) if (id < 0 && mm[(lg + k) % N].size() > 0) id = (lg + k) % N;
      if (id < 0) break;
      cnt = 0;
      do begin
        e = mm[id].pop_front();
        exp.push_back({2'(id), e[7:0]});
        cnt++;
      end while (!e[8] && cnt < MB && mm[id].size() > 0);
      lg = id;
    end
  endtask

  task automatic cmp_log(input string name, input logic [9:0] exp[$]);
    chk({name, "_count"}, 64'(log_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) chk($sformatf("%s_%0d", name, i), 64'(log_q[i]), 64'(exp[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp[$];
    logic [11:0] ord;
    int nm, len;
    tbl[0]  = '{3'b001, 3'b001, 24'h000041, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'h00};
    tbl[1]  = '{3'b001, 3'b001, 24'h000041, 1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 8'h41};
    tbl[2]  = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 8'h41};
    tbl[3]  = '{3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 8'h41};
    tbl[4]  = '{3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 8'h41};
    tbl[5]  = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'h41};
    tbl[6]  = '{3'b010, 3'b010, 24'h005200, 1'b0, 3'b010, 1'b0, 1'b1, 2'd1, 8'h41};
    tbl[7]  = '{3'b010, 3'b010, 24'h005200, 1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 8'h52};
    tbl[8]  = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 8'h52};
    tbl[9]  = '{3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd1, 8'h52};
    tbl[10] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 2'd1, 8'h52};
    tbl[11] = '{3'b001, 3'b000, 24'h000077, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'h52};
    tbl[12] = '{3'b001, 3'b000, 24'h000077, 1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 8'h77};
    tbl[13] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 8'h77};
    tbl[14] = '{3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 8'h77};
    tbl[15] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'h77};
    tbl[16] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'h77};
    tbl[17] = '{3'b100, 3'b100, 24'h990000, 1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'h77};
    tbl[18] = '{3'b101, 3'b001, 24'h990078, 1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 8'h78};
    tbl[19] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 8'h78};
    tbl[20] = '{3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 8'h78};
    tbl[21] = '{3'b000, 3'b000, 24'h000000, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0, 8'h78};

    do_reset();
    chk("reset_outputs", 64'({bus.req_ready, bus.tx_start, bus.grant_active, bus.grant_id, bus.tx_data, bus.err_timeout}), 0);

    man_en = 1'b1;
    for (int r = 0; r < 22; r++) begin
      bus.req_valid = tbl[r].v;
      bus.req_last = tbl[r].l;
      bus.req_data = tbl[r].d;
      man_busy = tbl[r].b;
      step();
      chk($sformatf("vec%0d", r), 64'({bus.req_ready, bus.tx_start, bus.grant_active, bus.grant_id, bus.tx_data}),
          64'({tbl[r].rdy, tbl[r].st, tbl[r].act, tbl[r].gid, tbl[r].txd}));
    end
    man_en = 1'b0;
    man_busy = 1'b0;

    do_reset();
    busy_len = 10;
    bus.req_valid = 3'b001;
    bus.req_last = 3'b001;
    bus.req_data = 24'h000041;
    wait_start("single_start");
    repeat (11) step();
    chk("single_busy_low_active", 64'({bus.tx_busy, bus.grant_active}), 64'(2'b01));
    step();
    chk("single_active_fall", 64'(bus.grant_active), 0);
    exp.delete();
    exp.push_back({2'd0, 8'h41});
    cmp_log("single", exp);

    do_reset();
    busy_len = 2;
    for (int i = 0; i < 3; i++) begin
      mq[0].push_back({1'b1, 8'hA0 + 8'(i)});
      mq[1].push_back({1'b1, 8'hB0 + 8'(i)});
    end
    predict(exp);
    run(500);
    cmp_log("rr", exp);
    ord = '0;
    for (int i = 0; i < 6; i++) ord = {ord[9:0], log_q[i][9:8]};
    chk("rr_order", 64'(ord), 64'(12'b00_01_00_01_00_01));

    do_reset();
    mq[0].push_back({1'b1, 8'h20});
    mq[0].push_back({1'b1, 8'h21});
    mq[1].push_back({1'b0, 8'h10});
    mq[1].push_back({1'b0, 8'h11});
    mq[1].push_back({1'b1, 8'h12});
    predict(exp);
    run(500);
    cmp_log("msg", exp);
    chk("msg_contig", 64'({log_q[1], log_q[2], log_q[3]}), 64'({2'd1, 8'h10, 2'd1, 8'h11, 2'd1, 8'h12}));

    do_reset();
    for (int i = 0; i < 12; i++) mq[0].push_back({1'b0, 8'h80 + 8'(i)});
    mq[1].push_back({1'b1, 8'h90});
    predict(exp);
    run(800);
    cmp_log("burst", exp);
    chk("burst_switch", 64'({log_q[3][9:8], log_q[4], log_q[5][9:8]}), 64'({2'd0, 2'd1, 8'h90, 2'd0}));

    for (int it = 0; it < 3; it++) begin
      do_reset();
      rnd_busy = 1'b1;
      for (int i = 0; i < N; i++) begin
        nm = int'($urandom_range(3, 1));
        for (int m = 0; m < nm; m++) begin
          len = int'($urandom_range(6, 1));
          for (int b = 0; b < len; b++) mq[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      predict(exp);
      run(3000);
      cmp_log($sformatf("rand%0d", it), exp);
      rnd_busy = 1'b0;
    end

    do_reset();
    stuck = 1'b1;
    bus.req_valid = 3'b001;
    bus.req_last = 3'b001;
    bus.req_data = 24'h000055;
    wait_start("to_start");
    repeat (7) step();
    chk("to_err_early", 64'(bus.err_timeout), 0);
    step();
    chk("to_err_rise", 64'({bus.err_timeout, bus.grant_active}), 64'(2'b10));
    bus.err_clr = 1'b1;
    step();
    chk("to_err_clr", 64'(bus.err_timeout), 0);
    bus.req_valid = 3'b001;
    wait_start("to_start2");
    repeat (8) step();
    chk("to_set_wins", 64'(bus.err_timeout), 1);
    bus.err_clr = 1'b0;
    step();
    chk("to_sticky", 64'(bus.err_timeout), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("to_clr2", 64'(bus.err_timeout), 0);
    stuck = 1'b0;

    do_reset();
    busy_len = 10;
    mq[0].push_back({1'b1, 8'hC0});
    run(200);
    bus.req_valid = 3'b010;
    bus.req_last = 3'b010;
    bus.req_data = 24'h00C100;
    wait_start("rst_start");
    step();
    step();
    chk("rst_in_wait", 64'({bus.grant_active, bus.tx_busy}), 64'(2'b11));
    rst = 1'b1;
    step();
    chk("rst_outputs", 64'({bus.req_ready, bus.tx_start, bus.grant_active, bus.grant_id, bus.tx_data, bus.err_timeout}), 0);
    rst = 1'b0;
    repeat (3) step();
    chk("rst_no_start", 64'(log_q.size()), 2);
    mq[0].push_back({1'b1, 8'hD0});
    mq[1].push_back({1'b1, 8'hD1});
    run(300);
    chk("rst_rr", 64'({log_q[2], log_q[3]}), 64'({2'd0, 8'hD0, 2'd1, 8'hD1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
